gumnut_data_mem_responder: RTL and testbench
============================================

# gumnut_data_mem_responder

Responder end of the Gumnut data bus: an 8-bit Wishbone-classic-style data memory that answers `cyc`/`stb`/`we` requests from the control unit with a single-cycle `ack`, after a programmable number of wait states. It sits between the processor's data port and on-chip RAM. It lets the `execute`/`mem` wait path of the control unit be exercised with realistic, non-zero memory latency.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `DEPTH`, 256: number of words. Must be a power of two and ≤ 2^ADDR_W.
- `WAIT_STATES`, 1: wait cycles inserted before `ack`. Legal range 0..15.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_cyc_i` in 1: bus cycle in progress.
- `data_stb_i` in 1: transfer strobe.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_adr_i` in ADDR_W: word address.
- `data_dat_i` in DATA_W: write data.
- `data_dat_o` out DATA_W: read data; valid only while `data_ack_o`=1, otherwise 0.
- `data_ack_o` out 1: transfer complete; one-cycle pulse per transfer.
- `data_err_o` out 1: transfer rejected. See Configuration.

## Operation
- Request = `data_cyc_i & data_stb_i`.
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - Request with WAIT_STATES=0 → RESP.
  - Request with WAIT_STATES>0 → WAIT; load the wait counter with WAIT_STATES-1.
  - Latch `we`, address and write data into the request registers on entry to either state.
- **WAIT**
  - Counter decrements each cycle; at 0 → RESP.
  - Request dropped (`cyc` or `stb` low) in any WAIT cycle → IDLE. This is an abort: no write, no ack, counter cleared.
- **RESP**
  - Exactly one cycle. `data_ack_o`=1 (or `data_err_o`=1).
  - Write: memory updated at the clock edge ending RESP, using the latched address and data.
  - Read: `data_dat_o` = mem[latched address].
  - Next state is always IDLE. If request is still high in IDLE, it is a new, independent transfer (classic back-to-back). There is no re-ack without passing through IDLE.
- Bus inputs changing during WAIT are ignored, except for abort; the latched values are used.
- Addressing: effective index = `data_adr_i[log2(DEPTH)-1:0]` (wrap-around) when the error feature is absent.
- Read-after-write to the same address in the next transfer returns the new data.

## Timing
- Reset (`rst_n`=0, async): state=IDLE, counter=0, `data_ack_o`=0, `data_err_o`=0, `data_dat_o`=0, latched request registers cleared. Memory contents are not reset.
- Reset asserted mid-transfer: the transfer is abandoned, no write occurs, and outputs are 0 immediately.
- Latency: request sampled at edge E0; ack is high in cycle E0+1+WAIT_STATES. Minimum 1 cycle (WAIT_STATES=0).
- Throughput: one transfer per WAIT_STATES+2 cycles under continuous request.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DMEM_ERR_EN` defined:
  - Addresses ≥ DEPTH complete with `data_err_o`=1 instead of `data_ack_o`, with the same timing.
  - Write suppressed, `data_dat_o`=0.
- `DMEM_ERR_EN` undefined:
  - `data_err_o` tied to 0.
  - Out-of-range addresses wrap modulo DEPTH and are acked normally.

## Test plan
- WAIT_STATES=2: write 0x5A to address 0x10, then read 0x10 → ack high exactly 3 cycles after each request edge; read returns 0x5A.
- WAIT_STATES=0, stb held high for 4 cycles, read of 0x03 preloaded with 0x77 → ack pulses on cycles 1 and 3, never two consecutive cycles; data 0x77 on each pulse.
- WAIT_STATES=3, write 0xFF to 0x20, stb dropped after 1 WAIT cycle, then read 0x20 (previously 0x11) → no ack for the aborted write; read returns 0x11.
- `rst_n` pulsed low during WAIT of a write of 0xAA to 0x05 (previously 0x33) → ack/err/dat go 0 immediately, state returns to IDLE; subsequent read of 0x05 returns 0x33.
- DEPTH=128, `DMEM_ERR_EN` defined: write 0x44 to 0x85 → `data_err_o` pulse, no ack; read of 0x05 unchanged. Without the macro: write acked, and read of 0x05 returns 0x44.

Source files
------------

// File: rtl/gumnut_data_mem_responder.sv
// gumnut_data_mem_responder
// Responder end of the Gumnut data bus: a Wishbone-classic style data RAM.
// A request (cyc & stb) is acknowledged after WAIT_STATES wait cycles with a
// single-cycle ack pulse. Transfers are strictly serialised through IDLE, so
// continuous requests complete once every WAIT_STATES+2 cycles.
//
// Handshake: a request is taken when cyc & stb are high in IDLE; the bus
// fields are latched at that edge and later changes are ignored. The only
// exception is cyc or stb going low during WAIT, which aborts the transfer
// (no write, no ack). ack/err are one-cycle pulses and dat_o is non-zero
// only while ack is high.
//
// Optional feature: define DMEM_ERR_EN to answer addresses >= DEPTH with
// data_err_o instead of data_ack_o (write suppressed, read data 0). Without
// it, data_err_o stays 0 and addresses wrap modulo DEPTH.
module gumnut_data_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_cyc_i,
   input  logic              data_stb_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_adr_i,
   input  logic [DATA_W-1:0] data_dat_i,
   output logic [DATA_W-1:0] data_dat_o,
   output logic              data_ack_o,
   output logic              data_err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   // Counter preload: WAIT lasts WAIT_STATES cycles (count WS-1 down to 0).
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q;
   logic                lat_we_q;
   logic [ADDR_W-1:0]   lat_adr_q;
   logic [DATA_W-1:0]   lat_dat_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                req;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_adr;
   logic                sel_oor;
   logic                lat_oor;
   logic                ack_d, err_d, mem_we;
   logic [DATA_W-1:0]   dat_d;
   logic                ack_q, err_q;
   logic [DATA_W-1:0]   dat_q;

   assign req = data_cyc_i & data_stb_i;

`ifdef DMEM_ERR_EN
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   assign sel_oor = ({1'b0, sel_adr} >= DEPTH_EXT);
   assign lat_oor = ({1'b0, lat_adr_q} >= DEPTH_EXT);
`else
   assign sel_oor = 1'b0;
   assign lat_oor = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: abort in WAIT has priority over the count reaching 0.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
         ST_WAIT: begin
            if (!req)               state_d = ST_IDLE;
            else if (cnt_q == 4'd0) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Request registers and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 4'd0;
         lat_we_q  <= 1'b0;
         lat_adr_q <= '0;
         lat_dat_q <= '0;
      end else if (state_q == ST_IDLE) begin
         if (req) begin
            lat_we_q  <= data_we_i;
            lat_adr_q <= data_adr_i;
            lat_dat_q <= data_dat_i;
            cnt_q     <= WS_LOAD;
         end
      end else if (state_q == ST_WAIT) begin
         if (!req)               cnt_q <= 4'd0;
         else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      end
   end

   // Transfer being resolved: with no wait states RESP is entered straight
   // from IDLE, so the live bus is used; otherwise the latched copy.
   always_comb begin
      sel_we  = lat_we_q;
      sel_adr = lat_adr_q;
      if (state_q == ST_IDLE) begin
         sel_we  = data_we_i;
         sel_adr = data_adr_i;
      end
   end

   // Output logic: next values of the registered bus outputs and write strobe.
   always_comb begin
      ack_d  = (state_d == ST_RESP) & ~sel_oor;
      err_d  = (state_d == ST_RESP) & sel_oor;
      dat_d  = '0;
      if (ack_d && !sel_we) dat_d = mem[sel_adr[IDX_W-1:0]];
      mem_we = (state_q == ST_RESP) & lat_we_q & ~lat_oor;
   end

   // Registered bus outputs, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
   end

   // Memory array (not reset); written at the edge that ends RESP.
   always_ff @(posedge clk) begin
      if (mem_we) mem[lat_adr_q[IDX_W-1:0]] <= lat_dat_q;
   end

   assign data_ack_o = ack_q;
   assign data_err_o = err_q;
   assign data_dat_o = dat_q;

endmodule

// File: tb/tb_gumnut_data_mem_responder.sv
// Self-checking bench for gumnut_data_mem_responder (default build, no
// DMEM_ERR_EN): WAIT_STATES=2, DEPTH=128 so address wrap is exercised.
module tb_gumnut_data_mem_responder;

   localparam int WS    = 2;
   localparam int DEPTH = 128;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cyc, stb, we;
   logic [7:0] adr, dat_i;
   logic [7:0] dat_o;
   logic       ack, err;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] ref_mem [DEPTH];
   logic [7:0] exp_q [$];

   gumnut_data_mem_responder #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .data_cyc_i(cyc), .data_stb_i(stb), .data_we_i(we),
      .data_adr_i(adr), .data_dat_i(dat_i),
      .data_dat_o(dat_o), .data_ack_o(ack), .data_err_o(err)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drop_req();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // Full transfer: request held until ack, bus fields scrambled during WAIT.
   task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
      int  n;
      bit  got;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
      if (!w) exp_q.push_back(ref_mem[a % DEPTH]);
      n = 0; got = 0;
      while (!got && n < WS + 6) begin
         @(posedge clk); #1; n++;
         if (ack || err) got = 1;
         else check("quiet_dat", 32'(dat_o), 32'h0);
         @(negedge clk);
         if (!got) begin
            we = 1'($urandom); adr = 8'($urandom); dat_i = 8'($urandom);
         end
      end
      if (!got) begin
         check("ack_timeout", 32'(got), 32'h1);
         if (!w) void'(exp_q.pop_front());
      end else begin
         check("latency", 32'(n), 32'(WS + 1));
         check("err_low", 32'(err), 32'h0);
         if (!w) check("rd_data", 32'(dat_o), 32'(exp_q.pop_front()));
      end
      if (w) ref_mem[a % DEPTH] = d;
      drop_req();
      @(posedge clk); #1;
      check("ack_pulse", 32'(ack), 32'h0);
      check("dat_idle", 32'(dat_o), 32'h0);
   endtask

   // Write aborted by dropping stb after k WAIT-entry edges (1..WS).
   task automatic bus_abort(input logic [7:0] a, input logic [7:0] d, input int k);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
         check("abort_noack", 32'(ack), 32'h0);
         @(negedge clk);
      end
      if ($urandom_range(0, 1) == 0) stb = 1'b0; else cyc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_quiet", 32'({ack, err}), 32'h0);
      end
      drop_req();
   endtask

   // Reset pulse either one cycle into WAIT or while the response is showing.
   task automatic rst_mid(input logic w, input logic [7:0] a, input logic [7:0] d, input bit in_resp);
      int n;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
      n = 0;
      if (in_resp) begin
         while (!ack && n < WS + 6) begin
            @(posedge clk); #1; n++;
         end
         check("resp_seen", 32'(ack), 32'h1);
      end else begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_dat", 32'(dat_o), 32'h0);
      @(negedge clk);
      drop_req();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_quiet", 32'(ack), 32'h0);
      end
   endtask

   // Request held high: expect isolated pulses every WS+2 cycles.
   task automatic held_read(input logic [7:0] a, input int cycles);
      logic exp_ack;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; dat_i = 8'h00;
      for (int i = 1; i <= cycles; i++) begin
         @(posedge clk); #1;
         exp_ack = ((i % (WS + 2)) == (WS + 1));
         check("held_ack", 32'(ack), 32'(exp_ack));
         check("held_dat", 32'(dat_o), exp_ack ? 32'(ref_mem[a % DEPTH]) : 32'h0);
      end
      @(negedge clk);
      drop_req();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] a, d;
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ack", 32'(ack), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      check("reset_dat", 32'(dat_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // fill memory so every later read has a known expected value
      for (int i = 0; i < DEPTH; i++) bus_xfer(1'b1, 8'(i), 8'($urandom));

      // write then read back
      bus_xfer(1'b1, 8'h10, 8'h5A);
      bus_xfer(1'b0, 8'h10, 8'h00);

      // continuous request
      bus_xfer(1'b1, 8'h03, 8'h77);
      held_read(8'h03, 12);

      // aborted write leaves old data
      bus_xfer(1'b1, 8'h20, 8'h11);
      bus_abort(8'h20, 8'hFF, 1);
      bus_xfer(1'b0, 8'h20, 8'h00);
      bus_abort(8'h20, 8'hEE, WS);
      bus_xfer(1'b0, 8'h20, 8'h00);

      // reset in WAIT and in RESP: write suppressed
      bus_xfer(1'b1, 8'h05, 8'h33);
      rst_mid(1'b1, 8'h05, 8'hAA, 1'b0);
      bus_xfer(1'b0, 8'h05, 8'h00);
      bus_xfer(1'b1, 8'h06, 8'h22);
      rst_mid(1'b1, 8'h06, 8'hCC, 1'b1);
      bus_xfer(1'b0, 8'h06, 8'h00);
      rst_mid(1'b0, 8'h06, 8'h00, 1'b1);

      // out-of-range address wraps modulo DEPTH
      bus_xfer(1'b1, 8'h85, 8'h44);
      bus_xfer(1'b0, 8'h05, 8'h00);
      bus_xfer(1'b0, 8'h85, 8'h00);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom);
         d = 8'($urandom);
         case ($urandom_range(0, 9))
            0:          bus_abort(a, d, $urandom_range(1, WS));
            1, 2, 3, 4: bus_xfer(1'b1, a, d);
            default:    bus_xfer(1'b0, a, d);
         endcase
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      held_read(8'($urandom), 9);

      check("exp_q_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
